// File: rtl/hazard_ctrl_if.sv
// Bus between the ID-stage decode/compare logic and hazard_ctrl.
// Optional performance counters appear only when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if;
   logic [4:0]  ifid_rs;
   logic [4:0]  ifid_rt;
   logic        ifid_uses_rt;
   logic        ifid_branch;
   logic        id_redirect;
   logic        idex_memread;
   logic        idex_regwrite;
   logic [4:0]  idex_rd;
   logic        exmem_memread;
   logic [4:0]  exmem_rd;
   logic        imem_ready;
   logic        c_PCWrite;
   logic        c_PCSrc;
   logic        c_IFIDWrite;
   logic        c_IFIDFlush;
   logic        c_IDEXBubble;
   logic        fetch_err;
`ifdef HAZARD_PERF_EN
   logic [15:0] stall_cycles;
   logic [15:0] flush_count;
   logic [15:0] imem_wait_cycles;
`endif

   // Pipeline side: drives decode/compare info, receives sequencing controls
   modport master (
`ifdef HAZARD_PERF_EN
      input  stall_cycles, flush_count, imem_wait_cycles,
`endif
      output ifid_rs, ifid_rt, ifid_uses_rt, ifid_branch, id_redirect,
      output idex_memread, idex_regwrite, idex_rd, exmem_memread, exmem_rd,
      output imem_ready,
      input  c_PCWrite, c_PCSrc, c_IFIDWrite, c_IFIDFlush, c_IDEXBubble, fetch_err
   );

   // Controller side
   modport slave (
`ifdef HAZARD_PERF_EN
      output stall_cycles, flush_count, imem_wait_cycles,
`endif
      input  ifid_rs, ifid_rt, ifid_uses_rt, ifid_branch, id_redirect,
      input  idex_memread, idex_regwrite, idex_rd, exmem_memread, exmem_rd,
      input  imem_ready,
      output c_PCWrite, c_PCSrc, c_IFIDWrite, c_IFIDFlush, c_IDEXBubble, fetch_err
   );
endinterface

// File: rtl/hazard_ctrl.sv
// IF/ID sequencing controller: load-use and branch stalls, redirect flushes,
// instruction-memory wait states and fetch timeout.
// Optional macro HAZARD_PERF_EN adds saturating 16-bit performance counters.
module hazard_ctrl #(
   parameter int unsigned MAX_IMEM_WAIT = 15,
   parameter int unsigned CNT_W         = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   hazard_ctrl_if.slave bus
);
   localparam int unsigned WAIT_W = $clog2(MAX_IMEM_WAIT + 1);

   typedef enum logic [1:0] {RUN, STALL, HALT} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [WAIT_W-1:0]   wait_inc;
   logic                fetch_err_q, fetch_err_d;

   logic m_idex, m_exmem, need2, need1;
   logic pc_write, pc_src, ifid_write, ifid_flush, idex_bubble;
   logic redirect_taken;

   // Register 0 is hardwired, so it can never create a dependency
   function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic uses_rt);
      return (rd != 5'd0) && ((rd == rs) || (uses_rt && (rd == rt)));
   endfunction

   // Stall need: 2 for a branch waiting on a load in EX, 1 for the shorter cases
   always_comb begin
      m_idex  = reg_match(bus.idex_rd,  bus.ifid_rs, bus.ifid_rt, bus.ifid_uses_rt);
      m_exmem = reg_match(bus.exmem_rd, bus.ifid_rs, bus.ifid_rt, bus.ifid_uses_rt);
      need2   = bus.ifid_branch & bus.idex_memread & m_idex;
      need1   = (bus.ifid_branch & bus.idex_regwrite & m_idex)
              | (bus.ifid_branch & bus.exmem_memread & m_exmem)
              | (~bus.ifid_branch & bus.idex_memread & m_idex);
      wait_inc = wait_cnt_q + WAIT_W'(1);
   end

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
         wait_cnt_q  <= '0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   // Next-state and combinational control outputs; priority stall > redirect > imem wait
   always_comb begin
      state_d        = state_q;
      stall_cnt_d    = stall_cnt_q;
      wait_cnt_d     = wait_cnt_q;
      fetch_err_d    = fetch_err_q;
      pc_write       = 1'b0;
      pc_src         = 1'b0;
      ifid_write     = 1'b0;
      ifid_flush     = 1'b0;
      idex_bubble    = 1'b0;
      redirect_taken = 1'b0;
      case (state_q)
         RUN: begin
            if (need2 || need1) begin
               idex_bubble = 1'b1;
               if (need2) begin
                  state_d     = STALL;
                  stall_cnt_d = CNT_W'(1);
               end
            end else if (bus.id_redirect) begin
               pc_write       = 1'b1;
               pc_src         = 1'b1;
               ifid_write     = 1'b1;
               ifid_flush     = 1'b1;
               redirect_taken = 1'b1;
               wait_cnt_d     = '0;
            end else if (bus.imem_ready) begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               wait_cnt_d = '0;
            end else begin
               ifid_write = 1'b1;
               ifid_flush = 1'b1;
               wait_cnt_d = wait_inc;
               if (wait_inc == WAIT_W'(MAX_IMEM_WAIT)) begin
                  fetch_err_d = 1'b1;
                  state_d     = HALT;
               end
            end
         end
         STALL: begin
            idex_bubble = 1'b1;
            stall_cnt_d = stall_cnt_q - CNT_W'(1);
            if (stall_cnt_q == CNT_W'(1)) state_d = RUN;
         end
         HALT: begin
            idex_bubble = 1'b1;
         end
         default: state_d = RUN;
      endcase
      // Reset holds the front end with a nop in ID and a bubble in EX
      if (!rst_n) begin
         pc_write       = 1'b0;
         pc_src         = 1'b0;
         ifid_write     = 1'b0;
         ifid_flush     = 1'b1;
         idex_bubble    = 1'b1;
         redirect_taken = 1'b0;
      end
   end

   assign bus.c_PCWrite    = pc_write;
   assign bus.c_PCSrc      = pc_src;
   assign bus.c_IFIDWrite  = ifid_write;
   assign bus.c_IFIDFlush  = ifid_flush;
   assign bus.c_IDEXBubble = idex_bubble;
   assign bus.fetch_err    = fetch_err_q;

`ifdef HAZARD_PERF_EN
   localparam int unsigned PERF_W = 16;
   logic [PERF_W-1:0] stall_cycles_q, flush_count_q, imem_wait_cycles_q;

   // Saturating event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q     <= '0;
         flush_count_q      <= '0;
         imem_wait_cycles_q <= '0;
      end else begin
         if (idex_bubble && (state_q != HALT) && (stall_cycles_q != '1))
            stall_cycles_q <= stall_cycles_q + PERF_W'(1);
         if (redirect_taken && (flush_count_q != '1))
            flush_count_q <= flush_count_q + PERF_W'(1);
         if ((state_q == RUN) && !bus.imem_ready && (imem_wait_cycles_q != '1))
            imem_wait_cycles_q <= imem_wait_cycles_q + PERF_W'(1);
      end
   end

   assign bus.stall_cycles     = stall_cycles_q;
   assign bus.flush_count      = flush_count_q;
   assign bus.imem_wait_cycles = imem_wait_cycles_q;
`endif
endmodule
